// File: rtl/pe_d_seq_ctrl_pkg.sv
// Shared definitions for the diagonal-PE chain sequencer: FSM states,
// PE control bundle and counter sizing helper.
package pe_d_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_EJECT   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic en_in;
        logic en_psum;
        logic ifmap_sel;
        logic eject;
    } pe_ctrl_t;

    localparam pe_ctrl_t PE_IDLE  = '{en_in: 1'b0, en_psum: 1'b0, ifmap_sel: 1'b0, eject: 1'b0};
    localparam pe_ctrl_t PE_MAC   = '{en_in: 1'b1, en_psum: 1'b1, ifmap_sel: 1'b1, eject: 1'b0};
    localparam pe_ctrl_t PE_DRAIN = '{en_in: 1'b1, en_psum: 1'b1, ifmap_sel: 1'b0, eject: 1'b0};
    localparam pe_ctrl_t PE_EJECT = '{en_in: 1'b0, en_psum: 1'b0, ifmap_sel: 1'b0, eject: 1'b1};

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_d_seq_ctrl_if.sv
// Scheduler/PE-chain side signals of the sequencer; slave = sequencer view.
interface pe_d_seq_ctrl_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned KW = 10
);
    logic          start;
    logic          abort;
    logic [KW-1:0] cfg_k_len;
    logic [AW-1:0] cfg_base_addr;
    logic          out_ready;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic          en_in;
    logic          en_psum;
    logic          en_out;
    logic          ifmap_sel_ctrl;
    logic          output_eject_ctrl;
    logic          out_valid;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, cfg_k_len, cfg_base_addr, out_ready,
        input  bram_en, bram_addr, en_in, en_psum, en_out, ifmap_sel_ctrl,
               output_eject_ctrl, out_valid, busy, done
    );

    modport slave (
        input  start, abort, cfg_k_len, cfg_base_addr, out_ready,
        output bram_en, bram_addr, en_in, en_psum, en_out, ifmap_sel_ctrl,
               output_eject_ctrl, out_valid, busy, done
    );
endinterface

// File: rtl/pe_d_seq_ctrl_step_counter.sv
// Loadable down-counter with enable; saturates at zero and flags it.
module pe_d_seq_ctrl_step_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (en_i && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/pe_d_seq_ctrl.sv
// Output-stationary tile sequencer for one diagonal-PE chain:
// prime the ifmap BRAM, K MAC cycles, skew drain, then eject N_PE psums.
module pe_d_seq_ctrl
    import pe_d_seq_ctrl_pkg::*;
#(
    parameter int unsigned N_PE = 16,
    parameter int unsigned AW   = 10,
    parameter int unsigned KW   = 10
) (
    input  logic            clk,
    input  logic            rst,
    pe_d_seq_ctrl_if.slave  ctrl
);
    localparam int unsigned CW = (KW > cnt_w(N_PE)) ? KW : cnt_w(N_PE);
    localparam int unsigned EW = cnt_w(N_PE);

    state_e        state_q;
    pe_ctrl_t      pe_q;
    logic [KW-1:0] k_len_q;
    logic [AW-1:0] addr_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;

    logic          step_load, step_en, step_zero;
    logic [CW-1:0] step_val;
    logic          ej_load, ej_en, ej_zero;
    logic          bram_en;

    // One counter times both COMPUTE (K) and DRAIN (N_PE-1); reloaded on the last MAC cycle.
    always_comb begin
        step_load = 1'b0;
        step_en   = 1'b0;
        step_val  = '0;
        ej_load   = 1'b0;
        ej_en     = 1'b0;
        case (state_q)
            ST_PRIME: begin
                step_load = 1'b1;
                step_val  = CW'(k_len_q) - CW'(1);
            end
            ST_COMPUTE: begin
                if (!step_zero) begin
                    step_en = 1'b1;
                end else if (N_PE > 1) begin
                    step_load = 1'b1;
                    step_val  = CW'(N_PE - 2);
                end else begin
                    ej_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (step_zero) ej_load = 1'b1;
                else           step_en = 1'b1;
            end
            ST_EJECT: ej_en = ctrl.out_ready;
            default: ;
        endcase
    end

    pe_d_seq_ctrl_step_counter #(.W(CW)) u_step_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (step_load),
        .en_i       (step_en),
        .load_val_i (step_val),
        .zero_o     (step_zero)
    );

    pe_d_seq_ctrl_step_counter #(.W(EW)) u_eject_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ej_load),
        .en_i       (ej_en),
        .load_val_i (EW'(N_PE - 1)),
        .zero_o     (ej_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pe_q        <= PE_IDLE;
            k_len_q     <= '0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (ctrl.abort && state_q != ST_IDLE) begin
            state_q     <= ST_IDLE;
            pe_q        <= PE_IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        k_len_q <= ctrl.cfg_k_len;
                        addr_q  <= ctrl.cfg_base_addr;
                        busy_q  <= 1'b1;
                        if (ctrl.cfg_k_len != '0) begin
                            state_q <= ST_PRIME;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_PRIME: begin
                    state_q <= ST_COMPUTE;
                    pe_q    <= PE_MAC;
                    addr_q  <= addr_q + 1'b1;
                end
                ST_COMPUTE: begin
                    if (!step_zero) begin
                        addr_q <= addr_q + 1'b1;
                    end else if (N_PE > 1) begin
                        state_q <= ST_DRAIN;
                        pe_q    <= PE_DRAIN;
                    end else begin
                        state_q     <= ST_EJECT;
                        pe_q        <= PE_EJECT;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (step_zero) begin
                        state_q     <= ST_EJECT;
                        pe_q        <= PE_EJECT;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_EJECT: begin
                    if (ctrl.out_ready && ej_zero) begin
                        state_q     <= ST_DONE;
                        pe_q        <= PE_IDLE;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read enable is decoded from state and the registered counter: the last MAC cycle issues no read.
    assign bram_en                = (state_q == ST_PRIME) || (state_q == ST_COMPUTE && !step_zero);
    assign ctrl.bram_en           = bram_en;
    assign ctrl.bram_addr         = bram_en ? addr_q : '0;
    assign ctrl.en_in             = pe_q.en_in;
    assign ctrl.en_psum           = pe_q.en_psum;
    assign ctrl.ifmap_sel_ctrl    = pe_q.ifmap_sel;
    assign ctrl.output_eject_ctrl = pe_q.eject;
    assign ctrl.out_valid         = out_valid_q;
    assign ctrl.en_out            = out_valid_q & ctrl.out_ready;
    assign ctrl.busy              = busy_q;
    assign ctrl.done              = done_q;
endmodule

// File: tb/tb_pe_d_seq_ctrl.sv
// Directed bench for pe_d_seq_ctrl with N_PE=4, AW=10, KW=10.
module tb_pe_d_seq_ctrl;
    localparam int unsigned N_PE = 4;
    localparam int unsigned AW   = 10;
    localparam int unsigned KW   = 10;

    typedef logic [18:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    pe_d_seq_ctrl_if #(.AW(AW), .KW(KW)) bus ();

    pe_d_seq_ctrl #(.N_PE(N_PE), .AW(AW), .KW(KW)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    // Output snapshot order: bram_en, bram_addr, en_in, en_psum, en_out, sel, eject, out_valid, busy, done
    function automatic obs_t snap();
        return {bus.bram_en, bus.bram_addr, bus.en_in, bus.en_psum, bus.en_out,
                bus.ifmap_sel_ctrl, bus.output_eject_ctrl, bus.out_valid, bus.busy, bus.done};
    endfunction

    function automatic obs_t mk(input logic be, input logic [9:0] a, input logic ei, input logic ep,
                                input logic eo, input logic sl, input logic ej, input logic ov,
                                input logic bz, input logic dn);
        return {be, a, ei, ep, eo, sl, ej, ov, bz, dn};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [KW-1:0] k, input logic [AW-1:0] base);
        bus.cfg_k_len     = k;
        bus.cfg_base_addr = base;
        bus.start         = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h, expected %h", snap(), obs_t'(0));
        end
        cyc();
        cyc();
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL reset_held: got %h, expected %h", snap(), obs_t'(0));
        end
        rst = 1'b1;
        cyc();
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: got %h, expected %h", snap(), obs_t'(0));
        end
    endtask

    task automatic test_basic();
        obs_t exp_tbl [13];
        exp_tbl = '{
            mk(1, 10'h010, 0, 0, 0, 0, 0, 0, 1, 0),
            mk(1, 10'h011, 1, 1, 0, 1, 0, 0, 1, 0),
            mk(1, 10'h012, 1, 1, 0, 1, 0, 0, 1, 0),
            mk(0, 10'h000, 1, 1, 0, 1, 0, 0, 1, 0),
            mk(0, 10'h000, 1, 1, 0, 0, 0, 0, 1, 0),
            mk(0, 10'h000, 1, 1, 0, 0, 0, 0, 1, 0),
            mk(0, 10'h000, 1, 1, 0, 0, 0, 0, 1, 0),
            mk(0, 10'h000, 0, 0, 1, 0, 1, 1, 1, 0),
            mk(0, 10'h000, 0, 0, 1, 0, 1, 1, 1, 0),
            mk(0, 10'h000, 0, 0, 1, 0, 1, 1, 1, 0),
            mk(0, 10'h000, 0, 0, 1, 0, 1, 1, 1, 0),
            mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 1, 1),
            mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0)
        };
        bus.out_ready = 1'b1;
        launch(10'd3, 10'h010);
        for (int c = 0; c < 13; c++) begin
            tests_run++;
            if (snap() !== exp_tbl[c]) begin
                tests_failed++;
                $display("FAIL basic_cycle%0d: got %h, expected %h", c + 1, snap(), exp_tbl[c]);
            end
            cyc();
        end
    endtask

    task automatic test_k_zero();
        launch(10'd0, 10'h155);
        tests_run++;
        if (snap() !== mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 1, 1)) begin
            tests_failed++;
            $display("FAIL kzero_done: got %h, expected %h", snap(), mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 1, 1));
        end
        cyc();
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL kzero_idle: got %h, expected %h", snap(), obs_t'(0));
        end
    endtask

    task automatic run_reads(input string name, input logic [KW-1:0] k, input logic [AW-1:0] base,
                             input int exp_done);
        logic [AW-1:0] addrs [$];
        int done_at = -1;
        launch(k, base);
        for (int c = 1; c <= 30; c++) begin
            if (bus.bram_en === 1'b1) addrs.push_back(bus.bram_addr);
            if (bus.done === 1'b1 && done_at < 0) done_at = c;
            cyc();
        end
        tests_run++;
        if (addrs.size() != int'(k)) begin
            tests_failed++;
            $display("FAIL %s_read_count: got %0d, expected %0d", name, addrs.size(), k);
        end
        for (int i = 0; i < int'(k); i++) begin
            tests_run++;
            if (i >= addrs.size() || addrs[i] !== AW'(base + AW'(i))) begin
                tests_failed++;
                $display("FAIL %s_addr%0d: got %h, expected %h", name, i,
                         (i < addrs.size()) ? addrs[i] : AW'(0), AW'(base + AW'(i)));
            end
        end
        tests_run++;
        if (done_at != exp_done) begin
            tests_failed++;
            $display("FAIL %s_done_cycle: got %0d, expected %0d", name, done_at, exp_done);
        end
    endtask

    task automatic test_wrap();
        // 1 + 4 + 3 + 4 + 1 cycles; reads 3FE,3FF,000,001
        bus.out_ready = 1'b1;
        run_reads("wrap", 10'd4, 10'h3FE, 13);
    endtask

    task automatic test_eject_stall();
        logic pat [7];
        int   n = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b0;
        launch(10'd1, 10'h000);
        while (bus.out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        tests_run++;
        if (n != 5) begin
            tests_failed++;
            $display("FAIL stall_eject_entry: got %0d cycles, expected 5", n);
        end
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i];
            #1;
            tests_run++;
            if ({bus.out_valid, bus.en_out, bus.done} !== {1'b1, pat[i], 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_beat%0d: got valid/en_out/done %b, expected %b", i,
                         {bus.out_valid, bus.en_out, bus.done}, {1'b1, pat[i], 1'b0});
            end
            cyc();
        end
        tests_run++;
        if (snap() !== mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 1, 1)) begin
            tests_failed++;
            $display("FAIL stall_done: got %h, expected %h", snap(), mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 1, 1));
        end
        bus.out_ready = 1'b1;
        cyc();
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL stall_idle: got %h, expected %h", snap(), obs_t'(0));
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        bus.out_ready = 1'b1;
        launch(10'd3, 10'h020);
        cyc();
        cyc();
        tests_run++;
        if (snap() !== mk(1, 10'h022, 1, 1, 0, 1, 0, 0, 1, 0)) begin
            tests_failed++;
            $display("FAIL abort_at_k1: got %h, expected %h", snap(), mk(1, 10'h022, 1, 1, 0, 1, 0, 0, 1, 0));
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL abort_idle: got %h, expected %h", snap(), obs_t'(0));
        end
        for (int c = 0; c < 15; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            cyc();
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d busy/done cycles, expected 0", dones);
        end
        // 1 + 2 + 3 + 4 + 1 cycles
        run_reads("after_abort", 10'd2, 10'h040, 11);
    endtask

    task automatic test_reset_mid_eject();
        int n = 0;
        int act = 0;
        bus.out_ready = 1'b0;
        launch(10'd1, 10'h100);
        while (bus.out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_eject_reached: got out_valid %b, expected 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (snap() !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_eject_async: got %h, expected %h", snap(), obs_t'(0));
        end
        cyc();
        cyc();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (snap() !== '0) act++;
            cyc();
        end
        tests_run++;
        if (act != 0) begin
            tests_failed++;
            $display("FAIL rst_after_release: got %0d active cycles, expected 0", act);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int done_at = -1;
        int busy_after = 0;
        bus.out_ready = 1'b1;
        launch(10'd1, 10'h000);
        bus.start         = 1'b1;
        bus.cfg_k_len     = 10'd0;
        bus.cfg_base_addr = 10'h2AA;
        for (int c = 1; c <= 15; c++) begin
            if (c == 11) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (c >= 11 && bus.busy !== 1'b0) busy_after++;
            cyc();
        end
        tests_run++;
        if (dones != 1 || done_at != 10) begin
            tests_failed++;
            $display("FAIL ignore_start_done: got %0d dones at cycle %0d, expected 1 at cycle 10", dones, done_at);
        end
        tests_run++;
        if (busy_after != 0) begin
            tests_failed++;
            $display("FAIL ignore_start_idle: got %0d busy cycles, expected 0", busy_after);
        end
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.cfg_k_len     = '0;
        bus.cfg_base_addr = '0;
        bus.out_ready     = 1'b0;
        test_reset();
        test_basic();
        test_k_zero();
        test_wrap();
        test_eject_stall();
        test_abort();
        test_reset_mid_eject();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end
endmodule
